// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment display driver: hex decode, leading-zero suppression,
// per-digit blanking, PWM brightness and frame-synchronous double-buffered data.
module seg7_mux_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned BRIGHT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              SegOut,
    output logic                    DpOut,
    output logic [NUM_DIGITS-1:0]   AnOut,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = 7'h7F;

    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic [BRIGHT_BITS-1:0] pwm_cnt;
    logic [DW-1:0]          sh_data, act_data;
    logic [NUM_DIGITS-1:0]  sh_dp, act_dp;
    logic [NUM_DIGITS-1:0]  sh_blank, act_blank;

    logic                   tick_c;
    logic                   commit_c;
    logic [IW-1:0]          idx_nxt_c;
    logic [BRIGHT_BITS-1:0] pwm_nxt_c;
    logic [DW-1:0]          act_data_nxt_c;
    logic [NUM_DIGITS-1:0]  act_dp_nxt_c;
    logic [NUM_DIGITS-1:0]  act_blank_nxt_c;
    logic [NUM_DIGITS-1:0]  supp_c;
    logic                   run_zero_c;
    logic [3:0]             nib_c;
    logic                   dp_sel_c;
    logic                   blank_sel_c;
    logic                   supp_sel_c;
    logic                   pwm_on_c;
    logic [NUM_DIGITS-1:0]  onehot_n_c;
    logic [6:0]             seg_c;
    logic                   dp_c;
    logic [NUM_DIGITS-1:0]  an_c;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Outputs are computed from next-state index/data so they change on the same
    // edge the index advances and a committed frame never shows stale digits.
    always_comb begin
        tick_c          = (presc == PRESC_LAST);
        commit_c        = tick_c && (idx == IDX_LAST);
        idx_nxt_c       = idx;
        if (tick_c) begin
            idx_nxt_c = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
        pwm_nxt_c       = pwm_cnt + BRIGHT_BITS'(1);
        act_data_nxt_c  = commit_c ? sh_data  : act_data;
        act_dp_nxt_c    = commit_c ? sh_dp    : act_dp;
        act_blank_nxt_c = commit_c ? sh_blank : act_blank;

        // Leading-zero chain runs from the top digit down; digit 0 is never touched.
        run_zero_c = 1'b1;
        supp_c     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero_c = run_zero_c & (act_data_nxt_c[4*i +: 4] == 4'h0);
            supp_c[i]  = lz_suppress & run_zero_c;
        end

        nib_c       = '0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        supp_sel_c  = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt_c == IW'(i)) begin
                nib_c       = act_data_nxt_c[4*i +: 4];
                dp_sel_c    = act_dp_nxt_c[i];
                blank_sel_c = act_blank_nxt_c[i];
                supp_sel_c  = supp_c[i];
            end
        end

        pwm_on_c   = (pwm_nxt_c <= brightness);
        onehot_n_c = ~(NUM_DIGITS'(1) << idx_nxt_c);

        seg_c = hex7(nib_c);
        dp_c  = ~dp_sel_c;
        an_c  = pwm_on_c ? onehot_n_c : '1;
        if (blank_sel_c) begin
            seg_c = SEG_OFF;
            dp_c  = 1'b1;
            an_c  = '1;
        end else if (supp_sel_c) begin
            // A suppressed digit may still carry a lit decimal point.
            seg_c = SEG_OFF;
            an_c  = (dp_sel_c && pwm_on_c) ? onehot_n_c : '1;
        end
    end

    // Slot timing and PWM counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc   <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick_c ? '0 : presc + PW'(1);
            idx     <= idx_nxt_c;
            pwm_cnt <= pwm_nxt_c;
        end
    end

    // Shadow/active double buffer; a coincident load lands in the shadow after the copy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            pending   <= 1'b0;
        end else begin
            act_data  <= act_data_nxt_c;
            act_dp    <= act_dp_nxt_c;
            act_blank <= act_blank_nxt_c;
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
                pending  <= 1'b1;
            end else if (commit_c) begin
                pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SegOut      <= SEG_OFF;
            DpOut       <= 1'b1;
            AnOut       <= '1;
            frame_start <= 1'b0;
        end else begin
            SegOut      <= seg_c;
            DpOut       <= dp_c;
            AnOut       <= an_c;
            frame_start <= commit_c;
        end
    end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clocks per digit slot, minimum 2.
REQ-003 SHALL have parameter BRIGHT_BITS, default 4: brightness and PWM counter width.
REQ-004 SHALL have port CLK  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  in  1  one-cycle strobe that captures data, dp_in and blank_in.
REQ-007 SHALL have port data  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
REQ-008 SHALL have port dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port blank_in  in  NUM_DIGITS  per-digit forced blank, 1 = dark.
REQ-010 SHALL have port lz_suppress  in  1  leading-zero suppression enable, sampled live.
REQ-011 SHALL have port brightness  in  BRIGHT_BITS  PWM duty select, sampled live.
REQ-012 SHALL have port SegOut  out  7  segments g..a on bits 6..0, active-low.
REQ-013 SHALL have port DpOut  out  1  decimal point, active-low.
REQ-014 SHALL have port AnOut  out  NUM_DIGITS  anode enables, active-low, bit i = digit i.
REQ-015 SHALL have port frame_start  out  1  one-cycle pulse when digit 0 slot begins.
REQ-016 SHALL have port pending  out  1  high while loaded values await commit.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL assert on the cycle the count equals CLK_DIV-1.
REQ-018 Digit index SHALL advance on tick, 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
REQ-019 load SHALL write data/dp_in/blank_in into a shadow register and set pending=1.
REQ-020 Shadow SHALL be copied to the active register on a tick where index = NUM_DIGITS-1 (frame boundary), clearing pending; the display SHALL never mix old and new values within a frame.
REQ-021 If load and commit coincide, the active register SHALL take the previous shadow contents, the shadow SHALL take the new values, and pending SHALL stay 1.
REQ-022 Multiple loads before commit: last load SHALL win.
REQ-023 Outputs SHALL be registered: SegOut/DpOut/AnOut SHALL reflect the new index one clock after the advancing tick.
REQ-024 Hex decode (g..a, active-low) SHALL be standard 0-9, A, b, C, d, E, F; e.g. 0 = 1000000, 8 = 0000000, F = 0001110, b = 0000011.
REQ-025 With lz_suppress=1, digit i>0 SHALL be suppressed when its nibble and all higher nibbles are 0; digit 0 SHALL never be suppressed.
REQ-026 Blanked digit (blank bit, or suppression): SegOut = 1111111, AnOut bit stays 1; DpOut follows dp bit only for suppressed (not blank_in) digits, with anode enabled.
REQ-027 Free-running PWM counter of BRIGHT_BITS SHALL increment every clock; active anode SHALL be enabled only when pwm_cnt <= brightness (all-ones = 100%, 0 = 1/2^BRIGHT_BITS duty).
REQ-028 At most one AnOut bit SHALL be 0 in any cycle.
REQ-029 frame_start SHALL pulse on the same cycle AnOut first selects digit 0 of each frame.

Reset
REQ-030 On RESET: prescaler, index, PWM counter = 0; shadow and active data/dp = 0, blank = all ones; pending = 0.
REQ-031 Outputs during and one cycle after RESET: SegOut = 1111111, DpOut = 1, AnOut = all ones, frame_start = 0.
REQ-032 RESET mid-frame or with pending=1 SHALL discard pending shadow data; load during RESET SHALL be ignored.

Verification (NUM_DIGITS=4, CLK_DIV=4, BRIGHT_BITS=2, brightness=3 unless stated)
REQ-033 Reset then no load -> AnOut stays 1111, SegOut 1111111 for 3 frames; frame_start pulses every 16 cycles.
REQ-034 load data=16'h12AF, blank_in=0 -> pending until boundary; next frame shows digit0 F (0001110), digit1 A, digit2 2, digit3 1, AnOut 1110,1101,1011,0111, 4 cycles each.
REQ-035 lz_suppress=1, data=16'h0030 -> digits 3,2 dark, digit1 3, digit0 0; data=16'h0000 -> only digit0 shows 0.
REQ-036 brightness=0 -> active anode low 1 of every 4 cycles; brightness=2 -> 3 of 4.
REQ-037 load 16'h1111 mid-frame, load 16'h2222 on commit cycle -> next frame 1111, following frame 2222, pending high across both commits until second.
REQ-038 RESET asserted with pending=1 mid-frame -> next cycle outputs dark, pending=0, prior load never displayed.
